cmp_sort_ctrl: RTL and testbench

//  Sequencer that sorts a block of DEPTH unsigned words in ascending order.

---
 rtl/cmp_sort_ctrl.sv | 98 +++++++++
 tb/tb_cmp_sort_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: loads a block of DEPTH words, bubble-sorts it ascending with an external comparator, then drains it
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid/in_ready    producer handshake; in_ready is high only while loading
//   in_data              word to load
//   out_valid/out_ready  consumer handshake; out_valid is high only while draining
//   out_data             sorted word, smallest first
//   busy                 high while sorting
//   cmp_a/cmp_b          comparator operands, the word at idx and the word after it
//   cmp_agtb             comparator A>B result, valid combinationally in the same cycle
//
// Build option: define CMP_SORT_EARLY_EXIT_EN to end sorting after the first pass that makes no swap.
module cmp_sort_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_agtb
);
  localparam int IDXW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 2);
  localparam logic [IDXW-1:0] LAST_WORD = IDXW'(DEPTH - 1);
  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] SORT = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] sortBuf [DEPTH];
  logic [IDXW-1:0] wr, rd, idx, pass, idxNext;
  logic doSwap, lastIdx, doneEarly;
  assign idxNext = idx + 1'b1;
  assign cmp_a = sortBuf[idx];
  assign cmp_b = sortBuf[idxNext];
  assign in_ready = state == LOAD;
  assign out_valid = state == DRAIN;
  assign busy = state == SORT;
  assign out_data = sortBuf[rd];
  // An unknown or low AgtB never swaps, which keeps equal words in load order.
  assign doSwap = busy && cmp_agtb;
  assign lastIdx = idx == LAST_IDX;
`ifdef CMP_SORT_EARLY_EXIT_EN
  logic swapFlag;
  // The pass is clean only if neither an earlier compare nor this final one swapped.
  assign doneEarly = !(swapFlag || doSwap);
  always_ff @(posedge clk or posedge rst)
    if (rst) swapFlag <= 1'b0;
    else if (busy) swapFlag <= lastIdx ? 1'b0 : (swapFlag || doSwap);
`else
  assign doneEarly = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= LOAD;
      wr <= '0;
      rd <= '0;
      idx <= '0;
      pass <= '0;
      for (int i = 0; i < DEPTH; i++) sortBuf[i] <= '0;
    end else begin
      case (state)
        LOAD:
          if (in_valid) begin
            sortBuf[wr] <= in_data;
            wr <= (wr == LAST_WORD) ? '0 : wr + 1'b1;
            if (wr == LAST_WORD) state <= SORT;
          end
        SORT: begin
          if (doSwap) begin
            sortBuf[idx] <= cmp_b;
            sortBuf[idxNext] <= cmp_a;
          end
          idx <= lastIdx ? '0 : idxNext;
          if (lastIdx) begin
            if (pass == LAST_IDX || doneEarly) begin
              state <= DRAIN;
              pass <= '0;
            end else pass <= pass + 1'b1;
          end
        end
        DRAIN:
          if (out_ready) begin
            rd <= (rd == LAST_WORD) ? '0 : rd + 1'b1;
            if (rd == LAST_WORD) state <= LOAD;
          end
        default: state <= LOAD;
      endcase
    end
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb_cmp_sort_ctrl: randomized and directed checks of cmp_sort_ctrl against a sort/pass-count reference model
module tb_cmp_sort_ctrl;
  localparam int W = 4;
  localparam int D = 4;
  typedef logic [D-1:0][W-1:0] blk_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, busy;
  logic [W-1:0] out_data, cmp_a, cmp_b;
  logic out_ready = 1'b0;
  logic cmp_agtb;
  int nCompared = 0;
  int nMismatch = 0;

  cmp_sort_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_agtb(cmp_agtb)
  );

  assign cmp_agtb = cmp_a > cmp_b;

  always #5 clk = ~clk;

  function automatic blk_t mk(input logic [W-1:0] a, b, c, d);
    blk_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  function automatic blk_t ref_sort(input blk_t w);
    int q[$];
    blk_t r;
    for (int i = 0; i < D; i++) q.push_back(int'(w[i]));
    q.sort();
    for (int i = 0; i < D; i++) r[i] = q[i][W-1:0];
    return r;
  endfunction

  // Bubble sort needs as many swapping passes as the largest count of bigger words
  // sitting ahead of any word; early exit adds one clean pass to notice it is done.
  function automatic int ref_busy(input blk_t w);
    int k = 0;
    for (int i = 0; i < D; i++) begin
      int c = 0;
      for (int j = 0; j < i; j++) if (w[j] > w[i]) c++;
      if (c > k) k = c;
    end
`ifdef CMP_SORT_EARLY_EXIT_EN
    return ((k + 1 < D - 1) ? k + 1 : D - 1) * (D - 1);
`else
    return (D - 1) * (D - 1);
`endif
  endfunction

  task automatic load_block(input blk_t w);
    for (int i = 0; i < D; i++) begin
      in_valid = 1'b1;
      in_data = w[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_block(input blk_t w, input bit junk, output int busyN, output blk_t got, output bit tmo);
    int g;
    tmo = 1'b0;
    busyN = 0;
    got = '0;
    load_block(w);
    in_valid = junk;
    in_data = 4'hF;
    while (busy && busyN < 200) begin
      busyN++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      g = 0;
      while (!out_valid && g < 50) begin
        g++;
        @(posedge clk); #1;
      end
      if (!out_valid) tmo = 1'b1;
      got[i] = out_data;
      if (i == D - 1) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    nCompared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      nMismatch++;
      $display("FAIL reset_status: in_ready=%b out_valid=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    end
    nCompared++;
    if (out_data !== '0 || cmp_a !== '0 || cmp_b !== '0) begin
      nMismatch++;
      $display("FAIL reset_data: out_data=%h cmp_a=%h cmp_b=%h expected 0 0 0", out_data, cmp_a, cmp_b);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_block(input string name, input blk_t w, input bit junk);
    int busyN;
    blk_t got, exp;
    bit tmo;
    exp = ref_sort(w);
    run_block(w, junk, busyN, got, tmo);
    nCompared++;
    if (busyN != ref_busy(w)) begin
      nMismatch++;
      $display("FAIL %s_busy: got %0d cycles expected %0d", name, busyN, ref_busy(w));
    end
    nCompared++;
    if (tmo || got !== exp) begin
      nMismatch++;
      $display("FAIL %s_drain: got %h expected %h timeout=%0d", name, got, exp, tmo);
    end
    nCompared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nMismatch++;
      $display("FAIL %s_reload: in_ready=%b out_valid=%b expected 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_first_compare;
    blk_t w;
    w = mk(4'h5, 4'h5, 4'h0, 4'hF);
    load_block(w);
    nCompared++;
    if (busy !== 1'b1 || cmp_a !== 4'h5 || cmp_b !== 4'h5) begin
      nMismatch++;
      $display("FAIL first_compare: busy=%b cmp_a=%h cmp_b=%h expected 1 5 5", busy, cmp_a, cmp_b);
    end
    while (busy) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    repeat (D) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    blk_t w, exp, got;
    int n;
    w = mk(4'h4, 4'h3, 4'h2, 4'h1);
    exp = ref_sort(w);
    load_block(w);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      nCompared++;
      if (out_valid !== 1'b1 || out_data !== exp[0]) begin
        nMismatch++;
        $display("FAIL hold_%0d: out_valid=%b out_data=%h expected 1 %h", i, out_valid, out_data, exp[0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    got = '0;
    for (int i = 0; i < D; i++) begin
      got[i] = out_valid ? out_data : 4'hx;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL backpressure_drain: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_reset_mid_sort;
    load_block(mk(4'h3, 4'hA, 4'h1, 4'h7));
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    nCompared++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || cmp_a !== '0) begin
      nMismatch++;
      $display("FAIL mid_sort_reset: busy=%b in_ready=%b out_valid=%b cmp_a=%h expected 0 1 0 0",
               busy, in_ready, out_valid, cmp_a);
    end
    @(posedge clk); #1 rst = 1'b0;
    test_block("after_reset", mk(4'h9, 4'h8, 4'h7, 4'h6), 1'b0);
  endtask

  task automatic test_partial_discard;
    in_valid = 1'b1;
    in_data = 4'hE;
    repeat (2) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    test_block("partial", mk(4'h2, 4'h0, 4'h1, 4'h3), 1'b0);
  endtask

  task automatic test_random;
    blk_t w;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < D; i++) w[i] = W'($urandom_range(0, 15));
      test_block($sformatf("rand%0d", t), w, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset;
    test_block("reverse", mk(4'h4, 4'h3, 4'h2, 4'h1), 1'b0);
    test_block("sorted", mk(4'h1, 4'h2, 4'h3, 4'h4), 1'b0);
    test_block("equal", mk(4'h5, 4'h5, 4'h0, 4'hF), 1'b0);
    test_first_compare;
    test_backpressure;
    test_reset_mid_sort;
    test_block("ignore_in", mk(4'h6, 4'h2, 4'h9, 4'h1), 1'b1);
    test_block("after_ignore", mk(4'h8, 4'h3, 4'h3, 4'h0), 1'b0);
    test_partial_discard;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
